// File: rtl/decoder_proj_pkg.sv
// Shared definitions for the decoder project: mode codes, the decode result
// record and the 7-segment glyph table.
package decoder_proj_pkg;

  localparam logic [1:0] MODE_HEX    = 2'b00;
  localparam logic [1:0] MODE_BCD    = 2'b01;
  localparam logic [1:0] MODE_ONEHOT = 2'b10;
  localparam logic [1:0] MODE_THERM  = 2'b11;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DEC_W  = 8;
  localparam int unsigned IO_W   = 7;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic [DEC_W-1:0] dec;
    logic             valid;
    logic             err;
  } dec_result_t;

  // Segment order is {g,f,e,d,c,b,a}; a set bit lights the segment.
  function automatic logic [SEG_W-1:0] seg7_glyph(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    case (nib)
      4'h0:    g = 7'b0111111;
      4'h1:    g = 7'b0000110;
      4'h2:    g = 7'b1011011;
      4'h3:    g = 7'b1001111;
      4'h4:    g = 7'b1100110;
      4'h5:    g = 7'b1101101;
      4'h6:    g = 7'b1111101;
      4'h7:    g = 7'b0000111;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1101111;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b1111100;
      4'hC:    g = 7'b0111001;
      4'hD:    g = 7'b1011110;
      4'hE:    g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/decoder_proj_core.sv
// Pure combinational decode of {mode, enable, data} into the segment pattern,
// one-hot/thermometer code and valid/err flags.
module decoder_proj_core
  import decoder_proj_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic        en,
  input  logic [3:0]  data,
  output dec_result_t res
);

  logic [DEC_W-1:0] onehot;
  logic [DEC_W-1:0] therm;

  always_comb begin
    onehot = '0;
    onehot[data[2:0]] = 1'b1;
  end

  // data[3] saturates the thermometer to all ones.
  always_comb begin
    if (data[3]) begin
      therm = '1;
    end else begin
      therm = onehot - 8'd1;
    end
  end

  always_comb begin
    res = '0;
    if (en) begin
      case (mode)
        MODE_HEX: begin
          res.seg   = seg7_glyph(data);
          res.valid = 1'b1;
        end
        MODE_BCD: begin
          if (data <= BCD_MAX) begin
            res.seg   = seg7_glyph(data);
            res.valid = 1'b1;
          end else begin
            res.err = 1'b1;
          end
        end
        MODE_ONEHOT: begin
          res.dec   = onehot;
          res.valid = 1'b1;
        end
        default: begin
          res.dec   = therm;
          res.valid = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decoder_proj_checker.sv
// Registered decoder harness: samples io_in, decodes it through the core and
// presents the result one cycle later; formal properties live under FORMAL.
module decoder_proj_checker
  import decoder_proj_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [IO_W-1:0] io_in,
  output logic [SEG_W-1:0] seg_out,
  output logic [DEC_W-1:0] dec_out,
  output logic             valid,
  output logic             err
);

  logic [1:0]  in_mode;
  logic        in_en;
  logic [3:0]  in_data;
  dec_result_t core_res;
  dec_result_t res_d;
  dec_result_t res_q;

  assign in_data = io_in[3:0];
  assign in_en   = io_in[4];
  assign in_mode = io_in[6:5];

  decoder_proj_core u_core (
    .mode (in_mode),
    .en   (in_en),
    .data (in_data),
    .res  (core_res)
  );

  always_comb begin
    res_d = core_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign seg_out = res_q.seg;
  assign dec_out = res_q.dec;
  assign valid   = res_q.valid;
  assign err     = res_q.err;

`ifdef FORMAL
  logic       past_rst_q;
  logic [1:0] mode_q;

  always_ff @(posedge clk) begin
    past_rst_q <= rst;
    mode_q     <= in_mode;
  end

  // Properties are meaningful only once the register holds a post-reset decode.
  always @(posedge clk) begin
    if (past_rst_q) begin
      assert (seg_out == '0 && dec_out == '0 && !valid && !err);
    end else begin
      if (valid && mode_q == MODE_ONEHOT) assert ($onehot(dec_out));
      if (err) assert (!valid);
      cover (valid && mode_q == MODE_HEX);
      cover (valid && mode_q == MODE_BCD);
      cover (valid && mode_q == MODE_ONEHOT);
      cover (valid && mode_q == MODE_THERM);
      cover (err);
    end
  end
`endif

endmodule

// File: tb/tb_decoder_proj_checker.sv
// Randomized self-checking bench for decoder_proj_checker against a table and
// arithmetic reference model.
module tb_decoder_proj_checker;

  logic       clk;
  logic       rst;
  logic [6:0] io_in;
  logic [6:0] seg_out;
  logic [7:0] dec_out;
  logic       valid;
  logic       err;

  int n_checks;
  int n_pass;

  logic [6:0] glyph_tbl [16];

  decoder_proj_checker dut (
    .clk     (clk),
    .rst     (rst),
    .io_in   (io_in),
    .seg_out (seg_out),
    .dec_out (dec_out),
    .valid   (valid),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {seg, dec, valid, err} straight from the decode rules.
  task automatic model(input logic [6:0] v, input logic r,
                       output logic [6:0] e_seg, output logic [7:0] e_dec,
                       output logic e_valid, output logic e_err);
    int mode;
    int d;
    mode = int'(v[6:5]);
    d    = int'(v[3:0]);
    e_seg = '0; e_dec = '0; e_valid = 1'b0; e_err = 1'b0;
    if (!r && v[4]) begin
      if (mode == 0) begin
        e_seg = glyph_tbl[d]; e_valid = 1'b1;
      end else if (mode == 1) begin
        if (d < 10) begin
          e_seg = glyph_tbl[d]; e_valid = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end else if (mode == 2) begin
        e_dec = 8'(1 << (d % 8)); e_valid = 1'b1;
      end else begin
        e_dec = (d >= 8) ? 8'hFF : 8'((1 << d) - 1); e_valid = 1'b1;
      end
    end
  endtask

  task automatic apply(input logic [6:0] v, input logic r, input string tag);
    logic [6:0] e_seg;
    logic [7:0] e_dec;
    logic       e_valid;
    logic       e_err;
    @(negedge clk);
    io_in = v;
    rst   = r;
    @(posedge clk);
    #1;
    model(v, r, e_seg, e_dec, e_valid, e_err);
    check({tag, ".seg"},   32'(seg_out), 32'(e_seg));
    check({tag, ".dec"},   32'(dec_out), 32'(e_dec));
    check({tag, ".valid"}, 32'(valid),   32'(e_valid));
    check({tag, ".err"},   32'(err),     32'(e_err));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    glyph_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                  7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                  7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    rst   = 1'b1;
    io_in = 7'h7F;

    apply(7'h7F, 1'b1, "reset0");
    apply(7'h7F, 1'b1, "reset1");

    // Directed vectors, including the BCD boundary at 9/10 and thermometer saturation.
    apply(7'b0010100, 1'b0, "hex4");
    check("hex4.seg_const", 32'(seg_out), 32'(7'b1100110));
    apply(7'b1010100, 1'b0, "onehot4");
    check("onehot4.dec_const", 32'(dec_out), 32'h10);
    apply(7'b0111100, 1'b0, "bcd12");
    check("bcd12.err_const", 32'(err), 32'd1);
    apply(7'b0110111, 1'b0, "bcd7");
    check("bcd7.seg_const", 32'(seg_out), 32'(7'b0000111));
    apply(7'b0111001, 1'b0, "bcd9");
    apply(7'b0111010, 1'b0, "bcd10");
    apply(7'b1110011, 1'b0, "therm3");
    check("therm3.dec_const", 32'(dec_out), 32'h07);
    apply(7'b1111011, 1'b0, "therm11");
    check("therm11.dec_const", 32'(dec_out), 32'hFF);
    apply(7'b1110000, 1'b0, "therm0");
    apply(7'b1000101, 1'b0, "en_drop");
    apply(7'b1111111, 1'b1, "rst_wins");

    for (int i = 0; i < 128; i++) begin
      apply(7'(i), 1'b0, "sweep");
    end

    for (int i = 0; i < 300; i++) begin
      apply(7'($urandom), ($urandom_range(15) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
